// File: rtl/state_machine_pkg.sv
// Shared constants for the JVM front-end state machine.
// Holds the state-output width, the address-ROM address width and the
// five legal state codes. Codes 5-7 of the 3-bit state space are illegal.
package me_consts;

    localparam int unsigned SMNL             = 3;
    localparam int unsigned adr_rom_adr_size = 8;
    localparam int unsigned BYTE_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_PARAM  = 3'd3,
        ST_EMIT   = 3'd4
    } state_t;

endpackage : me_consts

// File: rtl/state_machine_if.sv
// Bus between the instruction-RAM feeder and the state machine.
// Ports (master = feeder/bench side, slave = state machine):
//   waiting          feeder -> sm  stall request, 1 freezes the machine
//   iram_data        feeder -> sm  opcode or parameter byte
//   parameter_number feeder -> sm  parameter byte count, sampled in DECODE
//   state            sm -> feeder  current state code
//   com_adr          sm -> feeder  address-ROM index for the current opcode
//   jvm_opcode       sm -> feeder  latched opcode
//   q_select         sm -> feeder  queue for the current parameter byte
//   param_even       sm -> feeder  latched parameter count is even
interface state_machine_if
    import me_consts::*;
#(
    parameter int unsigned SMNL_W = me_consts::SMNL,
    parameter int unsigned ADR_W  = me_consts::adr_rom_adr_size
);

    logic                waiting;
    logic [BYTE_W-1:0]   iram_data;
    logic [BYTE_W-1:0]   parameter_number;
    logic [SMNL_W-1:0]   state;
    logic [ADR_W-1:0]    com_adr;
    logic [BYTE_W-1:0]   jvm_opcode;
    logic                q_select;
    logic                param_even;

    modport master (
        output waiting, iram_data, parameter_number,
        input  state, com_adr, jvm_opcode, q_select, param_even
    );

    modport slave (
        input  waiting, iram_data, parameter_number,
        output state, com_adr, jvm_opcode, q_select, param_even
    );

endinterface : state_machine_if

// File: rtl/state_machine.sv
// JVM opcode front-end sequencer.
// Walks IDLE -> FETCH -> DECODE -> (PARAM x N) -> EMIT -> FETCH, latching the
// opcode, its address-ROM index and the parameter count, and steering each
// parameter byte to the even/odd queue via q_select.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    state_machine_if.slave (stall, data in; state and outputs out)
module state_machine
    import me_consts::*;
#(
    parameter int unsigned SMNL             = me_consts::SMNL,
    parameter int unsigned adr_rom_adr_size = me_consts::adr_rom_adr_size
) (
    input  logic            clk,
    input  logic            reset,
    state_machine_if.slave  bus
);

    state_t                        r_state;
    logic [BYTE_W-1:0]             r_jvm_opcode;
    logic [adr_rom_adr_size-1:0]   r_com_adr;
    logic [BYTE_W-1:0]             r_counter;
    logic                          r_q_select;
    logic                          r_param_even;

    // Sequencer: every register advances only on a non-stalled edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_jvm_opcode <= '0;
            r_com_adr    <= '0;
            r_counter    <= '0;
            r_q_select   <= 1'b0;
            r_param_even <= 1'b0;
        end else if (!bus.waiting) begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_q_select <= 1'b0;
                end
                ST_FETCH: begin
                    r_jvm_opcode <= bus.iram_data;
                    r_q_select   <= 1'b0;
                    r_state      <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_com_adr    <= adr_rom_adr_size'(r_jvm_opcode);
                    r_counter    <= bus.parameter_number;
                    r_param_even <= ~bus.parameter_number[0];
                    r_q_select   <= 1'b0;
                    r_state      <= (bus.parameter_number == '0) ? ST_EMIT : ST_PARAM;
                end
                ST_PARAM: begin
                    // Counter saturates at zero so it can never wrap
                    if (r_counter != '0) begin
                        r_counter <= r_counter - 8'd1;
                    end
                    if (r_counter <= 8'd1) begin
                        r_state    <= ST_EMIT;
                        r_q_select <= 1'b0;
                    end else begin
                        r_q_select <= ~r_q_select;
                    end
                end
                ST_EMIT: begin
                    r_q_select <= 1'b0;
                    r_state    <= ST_FETCH;
                end
                default: begin
                    // Illegal codes recover to IDLE
                    r_q_select <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.state      = SMNL'(r_state);
    assign bus.jvm_opcode = r_jvm_opcode;
    assign bus.com_adr    = r_com_adr;
    assign bus.q_select   = r_q_select;
    assign bus.param_even = r_param_even;

endmodule : state_machine

// File: tb/tb_state_machine.sv
// Directed self-checking bench for state_machine.
module tb_state_machine;
    import me_consts::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    state_machine_if bus_if ();

    state_machine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, jvm_opcode, com_adr, q_select, param_even}
    function automatic logic [20:0] obs();
        return {bus_if.state, bus_if.jvm_opcode, bus_if.com_adr,
                bus_if.q_select, bus_if.param_even};
    endfunction

    function automatic logic [20:0] pk(input logic [2:0] s, input logic [7:0] op,
                                       input logic [7:0] ca, input logic qs,
                                       input logic pe);
        return {s, op, ca, qs, pe};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [20:0] e;
        reset = 1'b1;
        bus_if.waiting = 1'b0;
        bus_if.iram_data = 8'h00;
        bus_if.parameter_number = 8'h00;
        step();
        e = pk(3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", obs(), e);
        end
        reset = 1'b0;
        step();
        e = pk(3'd1, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs(), e);
        end
        bus_if.iram_data = 8'h5A;
        step();
        e = pk(3'd2, 8'h5A, 8'h00, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL pre_pulse_fetch got=%h exp=%h", obs(), e);
        end
        // Two-time-unit asynchronous pulse between edges
        reset = 1'b1;
        bus_if.iram_data = 8'd11;
        #1;
        e = pk(3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_pulse_async got=%h exp=%h", obs(), e);
        end
        #1;
        reset = 1'b0;
        step();
        e = pk(3'd1, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_pulse_first_edge got=%h exp=%h", obs(), e);
        end
    endtask

    // Entry in FETCH: opcode 0x10, two parameter bytes
    task automatic test_param2();
        logic [7:0]  din [5];
        logic [20:0] exp_t [5];
        din   = '{8'h10, 8'h00, 8'hAA, 8'hBB, 8'h00};
        exp_t = '{pk(3'd2, 8'h10, 8'h00, 1'b0, 1'b0),
                  pk(3'd3, 8'h10, 8'h10, 1'b0, 1'b1),
                  pk(3'd3, 8'h10, 8'h10, 1'b1, 1'b1),
                  pk(3'd4, 8'h10, 8'h10, 1'b0, 1'b1),
                  pk(3'd1, 8'h10, 8'h10, 1'b0, 1'b1)};
        bus_if.parameter_number = 8'd2;
        for (int k = 0; k < 5; k++) begin
            bus_if.iram_data = din[k];
            step();
            checks++;
            if (obs() !== exp_t[k]) begin
                failures++;
                $display("FAIL param2 step%0d got=%h exp=%h", k, obs(), exp_t[k]);
            end
        end
    endtask

    // Zero parameters; parameter_number is non-zero outside DECODE
    task automatic test_param0();
        logic [7:0]  pn [3];
        logic [20:0] exp_t [3];
        pn    = '{8'd5, 8'd0, 8'd5};
        exp_t = '{pk(3'd2, 8'h57, 8'h10, 1'b0, 1'b1),
                  pk(3'd4, 8'h57, 8'h57, 1'b0, 1'b1),
                  pk(3'd1, 8'h57, 8'h57, 1'b0, 1'b1)};
        bus_if.iram_data = 8'h57;
        for (int k = 0; k < 3; k++) begin
            bus_if.parameter_number = pn[k];
            step();
            checks++;
            if (obs() !== exp_t[k]) begin
                failures++;
                $display("FAIL param0 step%0d got=%h exp=%h", k, obs(), exp_t[k]);
            end
        end
    endtask

    task automatic test_param3();
        logic [20:0] exp_t [6];
        exp_t = '{pk(3'd2, 8'h33, 8'h57, 1'b0, 1'b1),
                  pk(3'd3, 8'h33, 8'h33, 1'b0, 1'b0),
                  pk(3'd3, 8'h33, 8'h33, 1'b1, 1'b0),
                  pk(3'd3, 8'h33, 8'h33, 1'b0, 1'b0),
                  pk(3'd4, 8'h33, 8'h33, 1'b0, 1'b0),
                  pk(3'd1, 8'h33, 8'h33, 1'b0, 1'b0)};
        bus_if.parameter_number = 8'd3;
        for (int k = 0; k < 6; k++) begin
            bus_if.iram_data = (k == 0) ? 8'h33 : 8'hC0 + 8'(k);
            step();
            checks++;
            if (obs() !== exp_t[k]) begin
                failures++;
                $display("FAIL param3 step%0d got=%h exp=%h", k, obs(), exp_t[k]);
            end
        end
    endtask

    // Four parameters with a three-cycle stall after the first PARAM edge
    task automatic test_stall();
        logic        wt [10];
        logic [20:0] exp_t [10];
        wt    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_t = '{pk(3'd2, 8'h21, 8'h33, 1'b0, 1'b0),
                  pk(3'd3, 8'h21, 8'h21, 1'b0, 1'b1),
                  pk(3'd3, 8'h21, 8'h21, 1'b1, 1'b1),
                  pk(3'd3, 8'h21, 8'h21, 1'b1, 1'b1),
                  pk(3'd3, 8'h21, 8'h21, 1'b1, 1'b1),
                  pk(3'd3, 8'h21, 8'h21, 1'b1, 1'b1),
                  pk(3'd3, 8'h21, 8'h21, 1'b0, 1'b1),
                  pk(3'd3, 8'h21, 8'h21, 1'b1, 1'b1),
                  pk(3'd4, 8'h21, 8'h21, 1'b0, 1'b1),
                  pk(3'd1, 8'h21, 8'h21, 1'b0, 1'b1)};
        for (int k = 0; k < 10; k++) begin
            bus_if.waiting = wt[k];
            bus_if.iram_data = (k == 0) ? 8'h21 : 8'h90 + 8'(k);
            // Stalled DECODE-time value would be odd; must not matter
            bus_if.parameter_number = (k == 1) ? 8'd4 : 8'd7;
            step();
            checks++;
            if (obs() !== exp_t[k]) begin
                failures++;
                $display("FAIL stall step%0d got=%h exp=%h", k, obs(), exp_t[k]);
            end
        end
        bus_if.waiting = 1'b0;
    endtask

    task automatic test_reset_mid_param();
        logic [20:0] e;
        logic [20:0] exp_t [4];
        bus_if.parameter_number = 8'd3;
        bus_if.iram_data = 8'h44;
        step();
        step();
        step();
        e = pk(3'd3, 8'h44, 8'h44, 1'b1, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL mid_param_pre got=%h exp=%h", obs(), e);
        end
        reset = 1'b1;
        #1;
        e = pk(3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL mid_param_abort got=%h exp=%h", obs(), e);
        end
        #1;
        reset = 1'b0;
        step();
        bus_if.iram_data = 8'h10;
        bus_if.parameter_number = 8'd1;
        exp_t = '{pk(3'd2, 8'h10, 8'h00, 1'b0, 1'b0),
                  pk(3'd3, 8'h10, 8'h10, 1'b0, 1'b0),
                  pk(3'd4, 8'h10, 8'h10, 1'b0, 1'b0),
                  pk(3'd1, 8'h10, 8'h10, 1'b0, 1'b0)};
        e = pk(3'd1, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL restart_fetch got=%h exp=%h", obs(), e);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (obs() !== exp_t[k]) begin
                failures++;
                $display("FAIL restart step%0d got=%h exp=%h", k, obs(), exp_t[k]);
            end
        end
    endtask

    // 255 parameters: exactly 255 PARAM cycles, no wrap
    task automatic test_param255();
        logic [20:0] e;
        int          cnt;
        int          budget;
        bus_if.iram_data = 8'hFF;
        bus_if.parameter_number = 8'd255;
        step();
        step();
        e = pk(3'd3, 8'hFF, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL p255_enter got=%h exp=%h", obs(), e);
        end
        cnt = 1;
        budget = 0;
        while (bus_if.state == 3'd3 && budget < 300) begin
            step();
            budget++;
            if (bus_if.state == 3'd3) cnt++;
        end
        checks++;
        if (cnt !== 255) begin
            failures++;
            $display("FAIL p255_count got=%0d exp=%0d", cnt, 255);
        end
        checks++;
        if (bus_if.state !== 3'd4) begin
            failures++;
            $display("FAIL p255_emit got=%0d exp=%0d", bus_if.state, 4);
        end
        step();
        checks++;
        if (bus_if.state !== 3'd1) begin
            failures++;
            $display("FAIL p255_fetch got=%0d exp=%0d", bus_if.state, 1);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_param2();
        test_param0();
        test_param3();
        test_stall();
        test_reset_mid_param();
        test_param255();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_state_machine

// File: doc/state_machine.md
STATE_MACHINE -- requirements
Module: state_machine

Interface
REQ-001 Parameter SMNL, default 3: width of the state output; the value lives in shared package me_consts.
REQ-002 Parameter adr_rom_adr_size, default 8: width of the address-ROM address; the value lives in me_consts.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 waiting  input  1  stall request from downstream; 1 freezes the machine.
REQ-006 iram_data  input  8  current byte from instruction RAM: opcode or parameter byte.
REQ-007 parameter_number  input  8  number of parameter bytes following the current opcode; valid in DECODE.
REQ-008 state  output  SMNL  current state encoding.
REQ-009 com_adr  output  adr_rom_adr_size  address-ROM index for the current opcode.
REQ-010 jvm_opcode  output  8  latched current JVM opcode.
REQ-011 q_select  output  1  destination queue of the current parameter byte: 0 = even index, 1 = odd index.
REQ-012 param_even  output  1  1 when the latched parameter count is even, including 0.

Function
REQ-013 States SHALL be encoded as: IDLE=0, FETCH=1, DECODE=2, PARAM=3, EMIT=4; codes 5-7 are illegal and SHALL go to IDLE on the next edge.
REQ-014 IDLE -> FETCH on the next edge unconditionally, unless stalled.
REQ-015 FETCH: jvm_opcode <= iram_data; next state DECODE.
REQ-016 DECODE: com_adr <= jvm_opcode zero-extended or truncated to adr_rom_adr_size.
REQ-017 DECODE: an 8-bit counter <= parameter_number; param_even <= ~parameter_number[0].
REQ-018 DECODE next state: EMIT if parameter_number==0, else PARAM.
REQ-019 PARAM: one iram_data byte is consumed per cycle.
REQ-020 PARAM: q_select is 0 for the first byte and toggles on every consumed byte.
REQ-021 PARAM: the counter decrements per byte; when the counter==1 the current byte is the last and the next state is EMIT.
REQ-022 parameter_number=255 SHALL produce exactly 255 PARAM cycles; the counter never wraps.
REQ-023 EMIT: next state FETCH; q_select <= 0.
REQ-024 Stall: while waiting=1 in any state, all registers and outputs SHALL hold.
REQ-025 Stall boundary: the byte on iram_data is consumed only on a non-stalled edge.
REQ-026 q_select SHALL be 0 in every state other than PARAM.
REQ-027 parameter_number SHALL be sampled only in DECODE; changes in other states have no effect.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 While reset=1: state=IDLE, jvm_opcode=0, com_adr=0, counter=0, q_select=0, param_even=0, asynchronously.
REQ-030 Reset asserted mid-PARAM or mid-stall SHALL abort immediately.
REQ-031 After reset deasserts, the first non-stalled edge moves IDLE -> FETCH.

Structure
REQ-032 me_consts SHALL hold: SMNL, adr_rom_adr_size, the five state codes.
REQ-033 The block is one module.
REQ-034 The block contains the state register, the opcode/com_adr registers, the 8-bit parameter counter and the q_select toggle.
REQ-035 No sub-module is required; the counter MAY be split out as sm_param_counter.

Verification
REQ-036 Reset pulse (2 time units) with iram_data=11 -> state=0 and all outputs 0 during reset; state=1 on the first edge after deassertion.
REQ-037 parameter_number=2, iram_data sequence 0x10,0xAA,0xBB -> states 1,2,3,3,4,1; jvm_opcode=0x10; com_adr=0x10; param_even=1; q_select 0 then 1 across the PARAM cycles.
REQ-038 parameter_number=0, opcode 0x57 -> FETCH,DECODE,EMIT,FETCH with no PARAM state; param_even=1; com_adr=0x57.
REQ-039 parameter_number=3 -> three PARAM cycles with q_select 0,1,0; param_even=0.
REQ-040 waiting=1 for 3 cycles during PARAM -> state, counter, q_select and outputs frozen; the sequence resumes exactly where it stopped.
REQ-041 reset asserted in the second PARAM cycle -> immediate IDLE with all outputs 0; a clean restart follows.
